pipelined_multiplier: RTL and testbench

- Pipelined shift-and-add multiply-accumulate, the inverse of the team's pipelined divider.
- Computes product = multiplicand * multiplier + addend, where multiplicand and addend are signed and multiplier is unsigned.
- Used to reconstruct a dividend from quotient/divisor/remainder (divider self-check, fixed-point rescaling). Carries the same 6-bit tag and valid sideband.
- One result per clock, no backpressure.

---
 rtl/pipelined_multiplier_pkg.sv | 14 +
 rtl/pipelined_multiplier_if.sv | 34 +++
 rtl/pipelined_multiplier_add_stage.sv | 62 ++++++
 rtl/pipelined_multiplier.sv | 110 +++++++++++
 tb/tb_pipelined_multiplier.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pipelined_multiplier_pkg.sv
// Shared constants for the divider/multiplier pair: tag width, default operand
// widths and the multiplier pipeline latency.
package pipelined_multiplier_pkg;

  localparam int TAG_WIDTH              = 6;
  localparam int DEFAULT_DIVIDEND_WIDTH = 12;
  localparam int DEFAULT_DIVISOR_WIDTH  = 6;

  // Input register + one add stage per multiplier bit + output register.
  function automatic int latency(input int divisor_width);
    return divisor_width + 2;
  endfunction

endpackage

// File: rtl/pipelined_multiplier_if.sv
// Sample/result bus of the pipelined multiply-accumulate.
// Handshake: input_valid qualifies input_tag/multiplicand/multiplier/addend on
// every rising clock; there is no ready, so the pipeline accepts every cycle.
// output_valid qualifies output_tag/product/overflow; the consumer cannot stall.
interface pipelined_multiplier_if
  import pipelined_multiplier_pkg::*;
#(
  parameter int dividend_width = DEFAULT_DIVIDEND_WIDTH,
  parameter int divisor_width  = DEFAULT_DIVISOR_WIDTH
);
  localparam int product_width = dividend_width + divisor_width;

  logic                      input_valid;
  logic [TAG_WIDTH-1:0]      input_tag;
  logic [dividend_width-1:0] multiplicand;
  logic [divisor_width-1:0]  multiplier;
  logic [dividend_width-1:0] addend;

  logic                      output_valid;
  logic [TAG_WIDTH-1:0]      output_tag;
  logic [product_width-1:0]  product;
  logic                      overflow;

  modport master (
    output input_valid, input_tag, multiplicand, multiplier, addend,
    input  output_valid, output_tag, product, overflow
  );

  modport slave (
    input  input_valid, input_tag, multiplicand, multiplier, addend,
    output output_valid, output_tag, product, overflow
  );

endinterface

// File: rtl/pipelined_multiplier_add_stage.sv
// One registered shift-add step: adds mcand << BIT when multiplier bit BIT is
// set; multiplicand, multiplier, valid and tag ride along unchanged.
module mult_add_stage
  import pipelined_multiplier_pkg::*;
#(
  parameter int PW  = 18,
  parameter int SW  = 6,
  parameter int BIT = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic [PW-1:0]        acc_i,
  input  logic [PW-1:0]        mcand_i,
  input  logic [SW-1:0]        mplier_i,
  output logic                 valid_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic [PW-1:0]        acc_o,
  output logic [PW-1:0]        mcand_o,
  output logic [SW-1:0]        mplier_o
);

  logic                 valid_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [PW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        mcand_q;
  logic [SW-1:0]        mplier_q;
  logic [PW-1:0]        partial;

  // Sum wraps modulo 2^PW; the result width is chosen so the true value never wraps.
  always_comb begin
    partial = '0;
    if (mplier_i[BIT]) begin
      partial = mcand_i << BIT;
    end
    acc_d = acc_i + partial;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      valid_q  <= valid_i;
      tag_q    <= tag_i;
      acc_q    <= acc_d;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
    end
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign acc_o    = acc_q;
  assign mcand_o  = mcand_q;
  assign mplier_o = mplier_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined shift-and-add multiply-accumulate:
// product = signed multiplicand * unsigned multiplier + signed addend.
module pipelined_multiplier
  import pipelined_multiplier_pkg::*;
#(
  parameter int dividend_width = DEFAULT_DIVIDEND_WIDTH,
  parameter int divisor_width  = DEFAULT_DIVISOR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pipelined_multiplier_if.slave bus
);

  localparam int product_width = dividend_width + divisor_width;

  // Stage 0 input registers.
  logic                     valid0_q;
  logic [TAG_WIDTH-1:0]     tag0_q;
  logic [product_width-1:0] acc0_q, acc0_d;
  logic [product_width-1:0] mcand0_q, mcand0_d;
  logic [divisor_width-1:0] mplier0_q;

  // Pipeline taps: index 0 is the input register, index i+1 the output of add stage i.
  logic                     pipe_valid  [0:divisor_width];
  logic [TAG_WIDTH-1:0]     pipe_tag    [0:divisor_width];
  logic [product_width-1:0] pipe_acc    [0:divisor_width];
  logic [product_width-1:0] pipe_mcand  [0:divisor_width];
  logic [divisor_width-1:0] pipe_mplier [0:divisor_width];

  // Output registers.
  logic                     output_valid_q;
  logic [TAG_WIDTH-1:0]     output_tag_q;
  logic [product_width-1:0] product_q;
  logic                     overflow_q, overflow_d;
  logic [divisor_width:0]   high_bits;

  always_comb begin
    acc0_d   = {{divisor_width{bus.addend[dividend_width-1]}}, bus.addend};
    mcand0_d = {{divisor_width{bus.multiplicand[dividend_width-1]}}, bus.multiplicand};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid0_q  <= 1'b0;
      tag0_q    <= '0;
      acc0_q    <= '0;
      mcand0_q  <= '0;
      mplier0_q <= '0;
    end else begin
      valid0_q  <= bus.input_valid;
      tag0_q    <= bus.input_tag;
      acc0_q    <= acc0_d;
      mcand0_q  <= mcand0_d;
      mplier0_q <= bus.multiplier;
    end
  end

  assign pipe_valid[0]  = valid0_q;
  assign pipe_tag[0]    = tag0_q;
  assign pipe_acc[0]    = acc0_q;
  assign pipe_mcand[0]  = mcand0_q;
  assign pipe_mplier[0] = mplier0_q;

  for (genvar i = 0; i < divisor_width; i++) begin : g_stage
    mult_add_stage #(
      .PW  (product_width),
      .SW  (divisor_width),
      .BIT (i)
    ) u_stage (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .valid_i  (pipe_valid[i]),
      .tag_i    (pipe_tag[i]),
      .acc_i    (pipe_acc[i]),
      .mcand_i  (pipe_mcand[i]),
      .mplier_i (pipe_mplier[i]),
      .valid_o  (pipe_valid[i+1]),
      .tag_o    (pipe_tag[i+1]),
      .acc_o    (pipe_acc[i+1]),
      .mcand_o  (pipe_mcand[i+1]),
      .mplier_o (pipe_mplier[i+1])
    );
  end

  // Overflow when the sign bit of a dividend_width result and everything above it disagree.
  always_comb begin
    high_bits  = pipe_acc[divisor_width][product_width-1:dividend_width-1];
    overflow_d = !((&high_bits) || !(|high_bits));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      output_valid_q <= 1'b0;
      output_tag_q   <= '0;
      product_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      output_valid_q <= pipe_valid[divisor_width];
      output_tag_q   <= pipe_tag[divisor_width];
      product_q      <= pipe_acc[divisor_width];
      overflow_q     <= overflow_d;
    end
  end

  assign bus.output_valid = output_valid_q;
  assign bus.output_tag   = output_tag_q;
  assign bus.product      = product_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed-vector bench for pipelined_multiplier with an expected-result queue
// aligned to the pipeline latency, plus a divider round-trip sweep.
module tb_pipelined_multiplier;
  import pipelined_multiplier_pkg::*;

  localparam int DW  = DEFAULT_DIVIDEND_WIDTH;
  localparam int SW  = DEFAULT_DIVISOR_WIDTH;
  localparam int PW  = DW + SW;
  localparam int LAT = latency(SW);
  localparam int EW  = 1 + TAG_WIDTH + PW + 1;

  logic clock;
  logic reset_n;

  pipelined_multiplier_if #(.dividend_width(DW), .divisor_width(SW)) bus ();

  pipelined_multiplier #(.dividend_width(DW), .divisor_width(SW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Called on the falling edge: one queue entry per sampled input cycle.
  task automatic compare_out();
    logic [EW-1:0]        e;
    logic                 e_v;
    logic [TAG_WIDTH-1:0] e_tag;
    logic [PW-1:0]        e_prod;
    logic                 e_ovf;
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      {e_v, e_tag, e_prod, e_ovf} = e;
      check_eq("output_valid", {31'd0, bus.output_valid}, {31'd0, e_v});
      if (e_v) begin
        check_eq("output_tag", {26'd0, bus.output_tag}, {26'd0, e_tag});
        check_eq("product", {14'd0, bus.product}, {14'd0, e_prod});
        check_eq("overflow", {31'd0, bus.overflow}, {31'd0, e_ovf});
      end
    end else begin
      check_eq("fill_valid", {31'd0, bus.output_valid}, 32'd0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [TAG_WIDTH-1:0] tag,
                       input logic [DW-1:0] mc, input logic [SW-1:0] mp,
                       input logic [DW-1:0] ad, input logic [PW-1:0] prod,
                       input logic ovf);
    bus.input_valid  = v;
    bus.input_tag    = tag;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    bus.addend       = ad;
    @(posedge clock);
    exp_q.push_back({v, tag, prod, ovf});
    @(negedge clock);
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  // ---------------- directed tables ----------------
  // Back-to-back stream, valid pattern 1101101111 (tag 0 first).
  logic            s_v    [0:9] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1};
  logic [DW-1:0]   s_mc   [0:9] = '{12'h001, 12'hFFE, 12'd10, 12'd100, 12'hF9C,
                                    12'd0, 12'h7FF, 12'h12C, 12'hFFF, 12'h021};
  logic [SW-1:0]   s_mp   [0:9] = '{6'd1, 6'd3, 6'd10, 6'd20, 6'd21,
                                    6'd63, 6'd2, 6'd7, 6'd63, 6'd62};
  logic [DW-1:0]   s_ad   [0:9] = '{12'd0, 12'd1, 12'd10, 12'hFFF, 12'd50,
                                    12'd7, 12'h800, 12'd0, 12'hFFF, 12'd5};
  logic [PW-1:0]   s_prod [0:9] = '{18'h00001, 18'h3FFFB, 18'h0006E, 18'h007CF, 18'h3F7FE,
                                    18'h00007, 18'h007FE, 18'h00834, 18'h3FFC0, 18'h00803};
  logic            s_ovf  [0:9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    int dividend, divisor, quo, rem;

    reset_n          = 1'b0;
    bus.input_valid  = 1'b0;
    bus.input_tag    = '0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;
    #1;
    check_eq("rst_valid", {31'd0, bus.output_valid}, 32'd0);
    check_eq("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check_eq("rst_product", {14'd0, bus.product}, 32'd0);
    check_eq("rst_tag", {26'd0, bus.output_tag}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic sign combinations and overflow boundaries.
    drive(1'b1, 6'h15, 12'd5,   6'd7,  12'd3,   18'd38,    1'b0);
    drive(1'b1, 6'h16, 12'hFFB, 6'd7,  12'hFFD, 18'h3FFDA, 1'b0);
    drive(1'b1, 6'h17, 12'h7FF, 6'd63, 12'd0,   18'h1F7C1, 1'b1);
    drive(1'b1, 6'h18, 12'h800, 6'd63, 12'h800, 18'h20000, 1'b1);
    drive(1'b1, 6'h19, 12'd100, 6'd0,  12'hFF0, 18'h3FFF0, 1'b0);
    drive(1'b1, 6'h1A, 12'h7FF, 6'd1,  12'd0,   18'h007FF, 1'b0);
    drive(1'b1, 6'h1B, 12'h7FF, 6'd1,  12'd1,   18'h00800, 1'b1);
    drive(1'b1, 6'h1C, 12'h800, 6'd1,  12'd0,   18'h3F800, 1'b0);
    drive(1'b1, 6'h1D, 12'h7FF, 6'd63, 12'h7FF, 18'h1FFC0, 1'b1);
    idle(LAT);

    for (int i = 0; i < 10; i++)
      drive(s_v[i], i[TAG_WIDTH-1:0], s_mc[i], s_mp[i], s_ad[i], s_prod[i], s_ovf[i]);
    idle(LAT);

    // Reset while results are emerging and more are in flight.
    for (int i = 0; i < 10; i++)
      drive(1'b1, 6'(i + 32), 12'(i), 6'd1, 12'd0, 18'(i), 1'b0);
    check_eq("pre_rst_valid", {31'd0, bus.output_valid}, 32'd1);
    bus.input_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, bus.output_valid}, 32'd0);
    check_eq("async_rst_product", {14'd0, bus.product}, 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    drive(1'b1, 6'h2A, 12'hFFF, 6'd2, 12'd4, 18'h00002, 1'b0);
    idle(LAT + 2);

    // Divider round trip: quotient * divisor + remainder rebuilds the dividend.
    for (int i = 0; i < 10000; i++) begin
      dividend = $urandom_range(0, 2047);
      divisor  = $urandom_range(1, 63);
      quo      = dividend / divisor;
      rem      = dividend % divisor;
      drive(1'b1, i[TAG_WIDTH-1:0], quo[DW-1:0], divisor[SW-1:0], rem[DW-1:0],
            dividend[PW-1:0], 1'b0);
    end
    idle(LAT);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
